hammer_key_filter: RTL and testbench
====================================

// Module: hammer_key_filter
// PURPOSE
//  Conditions raw USB keycode per frame before the sprite motion stage.
//  Maps unknown codes to 0x00 and debounces press and release over STABLE_FRAMES frames.
//  Emits one-frame press/release strobes.
//  Accumulates a saturating space-bar hold count (spin charge) for downstream throw logic.
// PARAMETERS
//  STABLE_FRAMES  2    consecutive matching frames to accept a press or release; legal 2..15
//  REPEAT_FRAMES  8    auto-repeat period in frames; used only with KEY_FILTER_AUTOREPEAT_EN
// PORTS
//  frame_clk      in   1   frame clock; all state updates on rising edge
//  Reset          in   1   asynchronous, active-high
//  keycode_in     in   8   raw keycode from USB host, may change any frame
//  keycode_out    out  8   debounced held key, 0x00 when none
//  key_valid      out  1   1 while keycode_out != 0x00
//  press_pulse    out  1   one-frame strobe on accepted press (and repeats, if enabled)
//  release_pulse  out  1   one-frame strobe on accepted release
//  spin_count     out  8   frames space (0x2C) held since its press; saturates at 255
// BEHAVIOUR
//  - Reset (async, any state): all outputs 0, raw_q=0, cnt=0, miss=0, state IDLE; no strobes.
//  - Filter: legal codes 04,07,16,1A,2C; any other value registers as 00.
//    raw_q <= filtered(keycode_in) every edge.
//  - IDLE: raw_q!=00 -> CAND, cand<=raw_q, cnt<=1.
//  - CAND, raw_q==cand:
//    - cnt==STABLE_FRAMES-1 -> HELD.
//    - keycode_out<=cand, press_pulse<=1, spin_count<=0, miss<=0.
//    - Otherwise cnt++.
//  - CAND, raw_q!=cand: raw_q==00 -> IDLE; else cand<=raw_q, cnt<=1.
//  - HELD, raw_q==keycode_out: miss<=0.
//    - If keycode_out==2C, spin_count++ saturating at 255.
//  - HELD, raw_q!=keycode_out (any mismatching code counts):
//    - miss==STABLE_FRAMES-1 -> release_pulse<=1, keycode_out<=00.
//      Then raw_q==00 -> IDLE; else CAND with cand<=raw_q, cnt<=1.
//    - Otherwise miss++ and keycode_out holds.
//  - Strobes are registered; they are high exactly one frame and otherwise 0.
//  - Latency: input stable before edge E -> press at edge E+STABLE_FRAMES.
//    Release latency is the same.
//  - Direct K1->K2 change:
//    - release K1 at miss expiry, then K2 press STABLE_FRAMES-1 edges later.
//    - Never press and release in the same frame.
//  - spin_count holds after release until the next accepted press clears it.
//  - Counters are 4-bit; spin_count never wraps.
// CONFIGURATION
//  KEY_FILTER_AUTOREPEAT_EN defined:
//  - In HELD with keycode_out in {04,07,16,1A}, rep counter runs.
//  - press_pulse re-asserts every REPEAT_FRAMES frames of uninterrupted hold.
//  - rep clears on press and on any miss frame.
//  - 0x2C never repeats.
//  KEY_FILTER_AUTOREPEAT_EN undefined: one press_pulse per accepted press; rep logic absent.
// TESTING
//  - Press A: keycode_in=04 from edge 1 (STABLE=2).
//    -> press_pulse=1 and keycode_out=04 after edge 3 only; key_valid=1.
//  - Glitch: keycode_in=07 for one frame, then 00.
//    -> no press_pulse; keycode_out stays 00.
//  - Release: hold 1A, then 00 for 1 frame, then 1A again.
//    -> no release.
//  - Release: hold 1A, then 00 for 2 frames.
//    -> release_pulse one frame; keycode_out=00.
//  - Spin: hold 2C for 300 frames after press.
//    -> spin_count=255 (saturated); after release it holds 255.
//    -> The next press clears it to 0.
//  - Illegal code 0x55 held -> treated as 00; no press.
//  - Reset asserted while HELD -> all outputs 0 immediately; no release_pulse.

Source files
------------

// File: rtl/hammer_key_filter.sv
// hammer_key_filter: filters and debounces per-frame USB keycodes into press/release strobes and a space-bar spin charge.
// Optional auto-repeat of held letter keys is enabled by defining KEY_FILTER_AUTOREPEAT_EN.
module hammer_key_filter #(
  parameter int STABLE_FRAMES = 2,
  parameter int REPEAT_FRAMES = 8
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode_in,
  output logic [7:0] keycode_out,
  output logic       key_valid,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] spin_count
);
  typedef enum logic [1:0] {IDLE, CAND, HELD} state_t;
  localparam logic [3:0] LAST = 4'(STABLE_FRAMES - 1);
  state_t state_q, state_d;
  logic [7:0] raw_q, raw_d, cand_q, cand_d, key_q, key_d, spin_q, spin_d;
  logic [3:0] cnt_q, cnt_d, miss_q, miss_d;
  logic press_q, press_d, rel_q, rel_d;
`ifdef KEY_FILTER_AUTOREPEAT_EN
  localparam logic [3:0] REP_LAST = 4'(REPEAT_FRAMES - 1);
  logic [3:0] rep_q, rep_d;
`endif
  always_comb begin
    raw_d = (keycode_in inside {8'h04, 8'h07, 8'h16, 8'h1A, 8'h2C}) ? keycode_in : 8'h00;
    state_d = state_q;
    cand_d = cand_q;
    cnt_d = cnt_q;
    miss_d = miss_q;
    key_d = key_q;
    spin_d = spin_q;
    press_d = 1'b0;
    rel_d = 1'b0;
`ifdef KEY_FILTER_AUTOREPEAT_EN
    rep_d = rep_q;
`endif
    case (state_q)
      IDLE: if (raw_q != 8'h00) begin
        state_d = CAND;
        cand_d = raw_q;
        cnt_d = 4'd1;
      end
      CAND: if (raw_q == cand_q) begin
        if (cnt_q == LAST) begin
          state_d = HELD;
          key_d = cand_q;
          press_d = 1'b1;
          spin_d = 8'h00;
          miss_d = 4'd0;
`ifdef KEY_FILTER_AUTOREPEAT_EN
          rep_d = 4'd0;
`endif
        end else cnt_d = cnt_q + 4'd1;
      end else if (raw_q == 8'h00) state_d = IDLE;
      else begin
        cand_d = raw_q;
        cnt_d = 4'd1;
      end
      HELD: if (raw_q == key_q) begin
        miss_d = 4'd0;
        spin_d = (key_q == 8'h2C && spin_q != 8'hFF) ? spin_q + 8'd1 : spin_q;
`ifdef KEY_FILTER_AUTOREPEAT_EN
        if (key_q != 8'h2C) begin
          press_d = rep_q == REP_LAST;
          rep_d = (rep_q == REP_LAST) ? 4'd0 : rep_q + 4'd1;
        end
`endif
      end else begin
`ifdef KEY_FILTER_AUTOREPEAT_EN
        rep_d = 4'd0;
`endif
        if (miss_q == LAST) begin
          rel_d = 1'b1;
          key_d = 8'h00;
          miss_d = 4'd0;
          state_d = (raw_q == 8'h00) ? IDLE : CAND;
          cand_d = raw_q;
          cnt_d = 4'd1;
        end else miss_d = miss_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      raw_q <= 8'h00;
      cand_q <= 8'h00;
      key_q <= 8'h00;
      spin_q <= 8'h00;
      cnt_q <= 4'd0;
      miss_q <= 4'd0;
      press_q <= 1'b0;
      rel_q <= 1'b0;
`ifdef KEY_FILTER_AUTOREPEAT_EN
      rep_q <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      raw_q <= raw_d;
      cand_q <= cand_d;
      key_q <= key_d;
      spin_q <= spin_d;
      cnt_q <= cnt_d;
      miss_q <= miss_d;
      press_q <= press_d;
      rel_q <= rel_d;
`ifdef KEY_FILTER_AUTOREPEAT_EN
      rep_q <= rep_d;
`endif
    end
  end
  assign keycode_out = key_q;
  assign key_valid = key_q != 8'h00;
  assign press_pulse = press_q;
  assign release_pulse = rel_q;
  assign spin_count = spin_q;
endmodule

// File: tb/tb_hammer_key_filter.sv
// tb_hammer_key_filter: directed vector table plus hand-written spin-saturation and async-reset sequences.
module tb_hammer_key_filter;
  logic frame_clk = 1'b0;
  logic Reset = 1'b1;
  logic [7:0] keycode_in = 8'h00;
  logic [7:0] keycode_out, spin_count;
  logic key_valid, press_pulse, release_pulse;
  int n_vec = 0;
  int n_err = 0;
  typedef struct {
    logic [7:0] kin;
    logic [7:0] key;
    logic       p;
    logic       r;
    logic [7:0] spin;
  } vec_t;
  vec_t vecs[35];
  hammer_key_filter #(.STABLE_FRAMES(2), .REPEAT_FRAMES(8)) dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .keycode_in(keycode_in),
    .keycode_out(keycode_out),
    .key_valid(key_valid),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .spin_count(spin_count)
  );
  always #5 frame_clk = ~frame_clk;
  task automatic step(input logic [7:0] k);
    keycode_in = k;
    @(posedge frame_clk);
    #1;
  endtask
  task automatic check(input string nm, input logic [7:0] k, input logic p, input logic r, input logic [7:0] s);
    n_vec++;
    if (keycode_out !== k || key_valid !== (k != 8'h00) || press_pulse !== p || release_pulse !== r || spin_count !== s) begin
      n_err++;
      $display("FAIL %s: got key=%h valid=%b press=%b rel=%b spin=%0d, want key=%h valid=%b press=%b rel=%b spin=%0d",
               nm, keycode_out, key_valid, press_pulse, release_pulse, spin_count, k, k != 8'h00, p, r, s);
    end
  endtask
  initial begin
    vecs = '{
      '{8'h04, 8'h00, 1'b0, 1'b0, 8'd0}, '{8'h04, 8'h00, 1'b0, 1'b0, 8'd0},
      '{8'h04, 8'h04, 1'b1, 1'b0, 8'd0}, '{8'h04, 8'h04, 1'b0, 1'b0, 8'd0},
      '{8'h00, 8'h04, 1'b0, 1'b0, 8'd0}, '{8'h00, 8'h04, 1'b0, 1'b0, 8'd0},
      '{8'h00, 8'h00, 1'b0, 1'b1, 8'd0}, '{8'h07, 8'h00, 1'b0, 1'b0, 8'd0},
      '{8'h00, 8'h00, 1'b0, 1'b0, 8'd0}, '{8'h00, 8'h00, 1'b0, 1'b0, 8'd0},
      '{8'h00, 8'h00, 1'b0, 1'b0, 8'd0}, '{8'h1A, 8'h00, 1'b0, 1'b0, 8'd0},
      '{8'h1A, 8'h00, 1'b0, 1'b0, 8'd0}, '{8'h1A, 8'h1A, 1'b1, 1'b0, 8'd0},
      '{8'h00, 8'h1A, 1'b0, 1'b0, 8'd0}, '{8'h1A, 8'h1A, 1'b0, 1'b0, 8'd0},
      '{8'h1A, 8'h1A, 1'b0, 1'b0, 8'd0}, '{8'h00, 8'h1A, 1'b0, 1'b0, 8'd0},
      '{8'h00, 8'h1A, 1'b0, 1'b0, 8'd0}, '{8'h00, 8'h00, 1'b0, 1'b1, 8'd0},
      '{8'h00, 8'h00, 1'b0, 1'b0, 8'd0}, '{8'h55, 8'h00, 1'b0, 1'b0, 8'd0},
      '{8'h55, 8'h00, 1'b0, 1'b0, 8'd0}, '{8'h55, 8'h00, 1'b0, 1'b0, 8'd0},
      '{8'h55, 8'h00, 1'b0, 1'b0, 8'd0}, '{8'h16, 8'h00, 1'b0, 1'b0, 8'd0},
      '{8'h16, 8'h00, 1'b0, 1'b0, 8'd0}, '{8'h16, 8'h16, 1'b1, 1'b0, 8'd0},
      '{8'h07, 8'h16, 1'b0, 1'b0, 8'd0}, '{8'h07, 8'h16, 1'b0, 1'b0, 8'd0},
      '{8'h07, 8'h00, 1'b0, 1'b1, 8'd0}, '{8'h07, 8'h07, 1'b1, 1'b0, 8'd0},
      '{8'h00, 8'h07, 1'b0, 1'b0, 8'd0}, '{8'h00, 8'h07, 1'b0, 1'b0, 8'd0},
      '{8'h00, 8'h00, 1'b0, 1'b1, 8'd0}
    };
    repeat (2) @(posedge frame_clk);
    #1;
    check("reset", 8'h00, 1'b0, 1'b0, 8'd0);
    Reset = 1'b0;
    for (int i = 0; i < 35; i++) begin
      step(vecs[i].kin);
      check($sformatf("vec%0d", i), vecs[i].key, vecs[i].p, vecs[i].r, vecs[i].spin);
    end
    step(8'h2C);
    step(8'h2C);
    step(8'h2C);
    check("spin_press", 8'h2C, 1'b1, 1'b0, 8'd0);
    for (int n = 1; n <= 300; n++) begin
      step(8'h2C);
      check($sformatf("spin%0d", n), 8'h2C, 1'b0, 1'b0, (n > 255) ? 8'd255 : 8'(n));
    end
    step(8'h00);
    check("spin_rel0", 8'h2C, 1'b0, 1'b0, 8'd255);
    step(8'h00);
    check("spin_rel1", 8'h2C, 1'b0, 1'b0, 8'd255);
    step(8'h00);
    check("spin_rel2", 8'h00, 1'b0, 1'b1, 8'd255);
    step(8'h04);
    step(8'h04);
    check("spin_hold", 8'h00, 1'b0, 1'b0, 8'd255);
    step(8'h04);
    check("spin_clear", 8'h04, 1'b1, 1'b0, 8'd0);
    step(8'h04);
    check("held_before_rst", 8'h04, 1'b0, 1'b0, 8'd0);
    Reset = 1'b1;
    #1;
    check("async_rst", 8'h00, 1'b0, 1'b0, 8'd0);
    step(8'h04);
    check("rst_hold", 8'h00, 1'b0, 1'b0, 8'd0);
    Reset = 1'b0;
    step(8'h00);
    check("post_rst0", 8'h00, 1'b0, 1'b0, 8'd0);
    step(8'h00);
    check("post_rst1", 8'h00, 1'b0, 1'b0, 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
